// File: rtl/data_tx_pkg.sv
// Shared constants and types for the capture-path byte packetizer.
package data_tx_pkg;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NUM_STATES = 11;

  localparam logic [BYTE_W-1:0] HDR0_DEF = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR1_DEF = 8'h5A;

  // One-hot bit positions
  localparam int unsigned S_IDLE       = 0;
  localparam int unsigned S_HDR_A      = 1;
  localparam int unsigned S_HDR_B      = 2;
  localparam int unsigned S_LEN_H      = 3;
  localparam int unsigned S_LEN_L      = 4;
  localparam int unsigned S_FETCH      = 5;
  localparam int unsigned S_WAIT_VALID = 6;
  localparam int unsigned S_SEND_HI    = 7;
  localparam int unsigned S_SEND_LO    = 8;
  localparam int unsigned S_CSUM       = 9;
  localparam int unsigned S_DONE       = 10;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE       = 11'b000_0000_0001,
    ST_HDR_A      = 11'b000_0000_0010,
    ST_HDR_B      = 11'b000_0000_0100,
    ST_LEN_H      = 11'b000_0000_1000,
    ST_LEN_L      = 11'b000_0001_0000,
    ST_FETCH      = 11'b000_0010_0000,
    ST_WAIT_VALID = 11'b000_0100_0000,
    ST_SEND_HI    = 11'b000_1000_0000,
    ST_SEND_LO    = 11'b001_0000_0000,
    ST_CSUM       = 11'b010_0000_0000,
    ST_DONE       = 11'b100_0000_0000
  } state_t;

  // Modulo-256 checksum accumulation; carries are dropped.
  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return BYTE_W'(acc + b);
  endfunction

endpackage

// File: rtl/data_tx_packetizer.sv
// Drains the 16-bit transfer FIFO one word at a time and frames the words as
// header, length, payload and checksum bytes on a valid/ready byte link.
import data_tx_pkg::*;

module data_tx_packetizer #(
  parameter int unsigned       PKT_WORDS = 128,
  parameter logic [BYTE_W-1:0] HDR0      = HDR0_DEF,
  parameter logic [BYTE_W-1:0] HDR1      = HDR1_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_not_empty_i,
  output logic              fifo_rd_o,
  input  logic              fifo_valid_i,
  input  logic [LEN_W-1:0]  fifo_dout_i,
  output logic              ready_to_transmit_o,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_stray_valid_o
);

  localparam logic [LEN_W-1:0] PKT_LEN = LEN_W'(PKT_WORDS);

  state_t            state_q;
  logic              fifo_rd_q;
  logic              tx_valid_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              frame_done_q;
  logic              err_q;
  logic [LEN_W-1:0]  word_cnt_q;
  logic [BYTE_W-1:0] csum_q;
  logic [BYTE_W-1:0] word_lo_q;

  logic              tx_fire;
  logic [BYTE_W-1:0] csum_sum;
  logic              last_word;

  // Byte accepted by the link this cycle, and the checksum including it.
  assign tx_fire   = tx_valid_q & tx_ready_i;
  assign csum_sum  = csum_add(csum_q, tx_data_q);
  assign last_word = (word_cnt_q + LEN_W'(1)) == PKT_LEN;

  // Frame sequencer with registered link, FIFO-read and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fifo_rd_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      word_cnt_q   <= '0;
      csum_q       <= '0;
      word_lo_q    <= '0;
    end else begin
      fifo_rd_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (fifo_valid_i && (state_q != ST_WAIT_VALID)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_not_empty_i) begin
            state_q    <= ST_HDR_A;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HDR0;
            word_cnt_q <= '0;
            csum_q     <= '0;
          end
        end
        ST_HDR_A: begin
          if (tx_fire) begin
            state_q   <= ST_HDR_B;
            tx_data_q <= HDR1;
          end
        end
        ST_HDR_B: begin
          if (tx_fire) begin
            state_q   <= ST_LEN_H;
            tx_data_q <= PKT_LEN[15:8];
          end
        end
        ST_LEN_H: begin
          if (tx_fire) begin
            state_q   <= ST_LEN_L;
            csum_q    <= csum_sum;
            tx_data_q <= PKT_LEN[7:0];
          end
        end
        ST_LEN_L: begin
          if (tx_fire) begin
            state_q    <= ST_FETCH;
            csum_q     <= csum_sum;
            tx_valid_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (fifo_not_empty_i) begin
            state_q   <= ST_WAIT_VALID;
            fifo_rd_q <= 1'b1;
          end
        end
        ST_WAIT_VALID: begin
          if (fifo_valid_i) begin
            state_q    <= ST_SEND_HI;
            word_lo_q  <= fifo_dout_i[7:0];
            tx_valid_q <= 1'b1;
            tx_data_q  <= fifo_dout_i[15:8];
          end
        end
        ST_SEND_HI: begin
          if (tx_fire) begin
            state_q   <= ST_SEND_LO;
            csum_q    <= csum_sum;
            tx_data_q <= word_lo_q;
          end
        end
        ST_SEND_LO: begin
          if (tx_fire) begin
            csum_q     <= csum_sum;
            word_cnt_q <= word_cnt_q + LEN_W'(1);
            if (last_word) begin
              state_q   <= ST_CSUM;
              tx_data_q <= csum_sum;
            end else begin
              state_q    <= ST_FETCH;
              tx_valid_q <= 1'b0;
            end
          end
        end
        ST_CSUM: begin
          if (tx_fire) begin
            state_q      <= ST_DONE;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_o           = fifo_rd_q;
  assign tx_valid_o          = tx_valid_q;
  assign tx_data_o           = tx_data_q;
  assign frame_done_o        = frame_done_q;
  assign err_stray_valid_o   = err_q;
  assign ready_to_transmit_o = state_q[S_IDLE];
  assign busy_o              = ~state_q[S_IDLE];

endmodule

// File: tb/tb_data_tx_packetizer.sv
// Directed bench for data_tx_packetizer with a small FIFO and link model.
module tb_data_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_ne = 1'b0;
  logic        fifo_rd;
  logic        fifo_valid = 1'b0;
  logic [15:0] fifo_dout = 16'h0;
  logic        rtt;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        err_stray;

  data_tx_packetizer #(.PKT_WORDS(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_not_empty_i    (fifo_ne),
    .fifo_rd_o           (fifo_rd),
    .fifo_valid_i        (fifo_valid),
    .fifo_dout_i         (fifo_dout),
    .ready_to_transmit_o (rtt),
    .tx_data_o           (tx_data),
    .tx_valid_o          (tx_valid),
    .tx_ready_i          (tx_ready),
    .busy_o              (busy),
    .frame_done_o        (frame_done),
    .err_stray_valid_o   (err_stray)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO / link model state
  logic [15:0] fifo_q[$];
  logic [7:0]  rx_q[$];
  logic [15:0] pend = 16'h0;
  int          lat = 1;
  int          vcnt = 0;
  int          ready_mode = 0;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          rd_cnt = 0;
  bit          stray_req = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;

  // Link sink and non-FWFT FIFO model, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (frame_done) fd_cnt++;
      if (fifo_rd) begin
        rd_cnt++;
        check("rd_while_empty", 32'(fifo_q.size() != 0), 32'd1);
      end
    end
    fifo_valid = 1'b0;
    if (vcnt > 0) begin
      vcnt--;
      if (vcnt == 0) begin
        fifo_valid = 1'b1;
        fifo_dout  = pend;
      end
    end
    if (stray_req) begin
      fifo_valid = 1'b1;
      fifo_dout  = 16'hDEAD;
      stray_req  = 1'b0;
    end
    if (fifo_rd && !rst && fifo_q.size() != 0) begin
      pend = fifo_q.pop_front();
      vcnt = lat;
    end
    fifo_ne = (fifo_q.size() != 0);
  end

  task automatic clear_model();
    fifo_q.delete();
    rx_q.delete();
    vcnt      = 0;
    fifo_ne   = 1'b0;
    stray_req = 1'b0;
    fd_cnt    = 0;
    rd_cnt    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(err_stray), 32'd0);
    check("rst_rtt", 32'(rtt), 32'd1);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_ne = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    check("wait_rx_reached", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [71:0] e, input int exp_rd);
    logic [7:0] got;
    check({tag, "_byte_count"}, 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(e[8*(8-i) +: 8]));
    end
    check({tag, "_rd_pulses"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_no_err"}, 32'(err_stray), 32'd0);
    check({tag, "_rtt_after"}, 32'(rtt), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] w0;
    logic [15:0] w1;
    int          mode;
    int          lat;
    logic [71:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int viol;
    vecs[0] = '{"basic",    16'h1234, 16'hABCD, 0, 1, 72'hA5_5A_00_02_12_34_AB_CD_C0};
    vecs[1] = '{"stalled",  16'h1234, 16'hABCD, 1, 1, 72'hA5_5A_00_02_12_34_AB_CD_C0};
    vecs[2] = '{"lat3",     16'h1234, 16'hABCD, 0, 3, 72'hA5_5A_00_02_12_34_AB_CD_C0};
    vecs[3] = '{"carry_ff", 16'hFFFF, 16'h0101, 1, 2, 72'hA5_5A_00_02_FF_FF_01_01_02};
    vecs[4] = '{"wrap_00",  16'h0000, 16'h00FE, 0, 1, 72'hA5_5A_00_02_00_00_00_FE_00};

    for (int r = 0; r < 5; r++) begin
      do_reset();
      ready_mode = vecs[r].mode;
      lat        = vecs[r].lat;
      push(vecs[r].w0);
      push(vecs[r].w1);
      wait_done(2000);
      check_frame(vecs[r].name, vecs[r].exp, 2);
    end

    // FIFO runs dry after the first word: FSM must sit quietly in FETCH.
    do_reset();
    ready_mode = 0;
    lat        = 1;
    push(16'h1234);
    wait_rx(6, 500);
    repeat (3) @(negedge clk);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd || tx_valid || !busy) viol++;
    end
    check("dry_fetch_quiet", 32'(viol), 32'd0);
    check("dry_one_read", 32'(rd_cnt), 32'd1);
    push(16'hABCD);
    wait_done(2000);
    check_frame("dry", 72'hA5_5A_00_02_12_34_AB_CD_C0, 2);

    // Reset mid-frame after 0x12 went out; next frame restarts cleanly.
    do_reset();
    ready_mode = 0;
    lat        = 1;
    push(16'h1234);
    push(16'hABCD);
    wait_rx(5, 500);
    check("abort_last_byte", 32'(rx_q[4]), 32'h12);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_rtt", 32'(rtt), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    clear_model();
    push(16'h1234);
    push(16'hABCD);
    wait_done(2000);
    check_frame("restart", 72'hA5_5A_00_02_12_34_AB_CD_C0, 2);

    // Stray fifo_valid while idle sets the sticky error and emits nothing.
    do_reset();
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_err_set", 32'(err_stray), 32'd1);
    repeat (20) @(negedge clk);
    check("stray_err_sticky", 32'(err_stray), 32'd1);
    check("stray_no_bytes", 32'(rx_q.size()), 32'd0);
    check("stray_tx_valid", 32'(tx_valid), 32'd0);
    check("stray_rtt", 32'(rtt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
